// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
//
// Program-counter controller for a small sequential core. Holds a three-state
// execution FSM (IDLE -> RUN -> DONE), a branch/jump target look-up table and
// an executed-instruction counter. Every RUN cycle performs exactly one pc
// update. The priority order is halt, then taken branch, then jump, then the
// sequential pc+1.
//
// Parameters
//   PC_W        program counter width in bits
//   LUT_N       number of branch-target LUT entries (power of two)
//
// Ports
//   CLK         single clock, all state updates on the rising edge
//   Reset       synchronous, active-high; clears FSM, pc, counters and LUT
//   start       begin execution from pc=0 (IDLE or DONE only)
//   halt        decoded halt at the current pc (RUN only)
//   branch_en   decoded conditional branch at the current pc (RUN only)
//   z           branch condition; a branch is taken when 1
//   jump_en     decoded unconditional jump at the current pc (RUN only)
//   target_idx  LUT index supplying the branch/jump target
//   lut_we      LUT write enable (any state)
//   lut_waddr   LUT write address
//   lut_wdata   LUT write data (absolute target address)
//   pc          current instruction address (registered)
//   fetch_valid pc holds a live instruction this cycle (registered)
//   done        program finished (registered)
//   cycle_cnt   executed-instruction count, saturating (registered)
// -----------------------------------------------------------------------------
module pc_ctrl #(
  parameter  int PC_W  = 10,
  parameter  int LUT_N = 16,
  localparam int IDX_W = $clog2(LUT_N)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic              halt,
  input  logic              branch_en,
  input  logic              z,
  input  logic              jump_en,
  input  logic [IDX_W-1:0]  target_idx,
  input  logic              lut_we,
  input  logic [IDX_W-1:0]  lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              fetch_valid,
  output logic              done,
  output logic [15:0]       cycle_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t            state_r;
  logic [PC_W-1:0]   pc_r;
  logic              fetch_valid_r;
  logic              done_r;
  logic [15:0]       cycle_cnt_r;

  logic [PC_W-1:0]   lut_r [LUT_N];

  logic [PC_W-1:0]   target_s;
  logic              redirect_s;
  logic [PC_W-1:0]   pc_inc_s;
  logic [15:0]       cnt_next_s;

  // Next-value helpers: combinational LUT read, redirect decode, pc+1 and
  // saturating counter increment.
  always_comb begin
    // Reading the registered array here gives read-before-write behaviour:
    // a same-cycle write only becomes visible after the edge.
    target_s   = lut_r[target_idx];
    redirect_s = (branch_en & z) | jump_en;
    // Natural truncation to PC_W bits provides the all-ones -> 0 wrap.
    pc_inc_s   = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    if (cycle_cnt_r == 16'hFFFF) begin
      cnt_next_s = cycle_cnt_r;
    end else begin
      cnt_next_s = cycle_cnt_r + 16'd1;
    end
  end

  // Execution FSM with all outputs registered alongside the state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= {PC_W{1'b0}};
      fetch_valid_r <= 1'b0;
      done_r        <= 1'b0;
      cycle_cnt_r   <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r       <= ST_RUN;
            pc_r          <= {PC_W{1'b0}};
            fetch_valid_r <= 1'b1;
            done_r        <= 1'b0;
            cycle_cnt_r   <= 16'd0;
          end
        end
        ST_RUN: begin
          // The halt cycle still counts as an executed instruction.
          cycle_cnt_r <= cnt_next_s;
          if (halt) begin
            state_r       <= ST_DONE;
            fetch_valid_r <= 1'b0;
            done_r        <= 1'b1;
          end else if (redirect_s) begin
            pc_r <= target_s;
          end else begin
            pc_r <= pc_inc_s;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_r       <= ST_RUN;
            pc_r          <= {PC_W{1'b0}};
            fetch_valid_r <= 1'b1;
            done_r        <= 1'b0;
            cycle_cnt_r   <= 16'd0;
          end
        end
        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          state_r       <= ST_IDLE;
          pc_r          <= {PC_W{1'b0}};
          fetch_valid_r <= 1'b0;
          done_r        <= 1'b0;
          cycle_cnt_r   <= 16'd0;
        end
      endcase
    end
  end

  // Branch-target LUT: cleared by reset, writable in every state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut_r[i] <= {PC_W{1'b0}};
      end
    end else if (lut_we) begin
      lut_r[lut_waddr] <= lut_wdata;
    end
  end

  assign pc          = pc_r;
  assign fetch_valid = fetch_valid_r;
  assign done        = done_r;
  assign cycle_cnt   = cycle_cnt_r;

endmodule

// File: tb/tb_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_ctrl
//
// Scoreboard bench for pc_ctrl. The stimulus process drives inputs one cycle
// at a time, advances a behavioural model of the program counter, and queues
// the expected post-edge outputs. A monitor on the falling edge pops each
// expectation and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pc_ctrl;

  localparam int PC_W  = 10;
  localparam int LUT_N = 16;
  localparam int IDX_W = 4;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              start;
  logic              halt;
  logic              branch_en;
  logic              z;
  logic              jump_en;
  logic [IDX_W-1:0]  target_idx;
  logic              lut_we;
  logic [IDX_W-1:0]  lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              fetch_valid;
  logic              done;
  logic [15:0]       cycle_cnt;

  pc_ctrl #(.PC_W(PC_W), .LUT_N(LUT_N)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .start       (start),
    .halt        (halt),
    .branch_en   (branch_en),
    .z           (z),
    .jump_en     (jump_en),
    .target_idx  (target_idx),
    .lut_we      (lut_we),
    .lut_waddr   (lut_waddr),
    .lut_wdata   (lut_wdata),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .done        (done),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int    pc;
    int    fv;
    int    dn;
    int    cnt;
    string tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: "running"/"finished" flags, pc as an integer modulo
  // 2^PC_W, and a plain integer array for the target table.
  bit m_running;
  bit m_finished;
  int m_pc;
  int m_cnt;
  int m_lut [LUT_N];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Monitor: one expectation per clock, compared mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".pc"},          int'(pc),          e.pc);
      chk({e.tag, ".fetch_valid"}, int'(fetch_valid), e.fv);
      chk({e.tag, ".done"},        int'(done),        e.dn);
      chk({e.tag, ".cycle_cnt"},   int'(cycle_cnt),   e.cnt);
    end
  end

  task automatic quiet();
    Reset      = 1'b0;
    start      = 1'b0;
    halt       = 1'b0;
    branch_en  = 1'b0;
    z          = 1'b0;
    jump_en    = 1'b0;
    target_idx = '0;
    lut_we     = 1'b0;
    lut_waddr  = '0;
    lut_wdata  = '0;
  endtask

  // Apply current inputs for one clock and queue the model's prediction.
  task automatic tick(input string tag);
    exp_t e;
    int   tgt;
    if (Reset === 1'b1) begin
      m_running  = 1'b0;
      m_finished = 1'b0;
      m_pc       = 0;
      m_cnt      = 0;
      for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
    end else begin
      tgt = m_lut[int'(target_idx)];
      if (lut_we) m_lut[int'(lut_waddr)] = int'(lut_wdata);
      if (m_running) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (halt) begin
          m_running  = 1'b0;
          m_finished = 1'b1;
        end else if ((branch_en && z) || jump_en) begin
          m_pc = tgt;
        end else begin
          m_pc = (m_pc + 1) % (1 << PC_W);
        end
      end else if (start) begin
        m_running  = 1'b1;
        m_finished = 1'b0;
        m_pc       = 0;
        m_cnt      = 0;
      end
    end
    e.pc  = m_pc;
    e.fv  = m_running ? 1 : 0;
    e.dn  = m_finished ? 1 : 0;
    e.cnt = m_cnt;
    e.tag = tag;
    @(posedge CLK);
    q.push_back(e);
    #1;
  endtask

  task automatic write_lut(input int idx, input int val, input string tag);
    quiet();
    lut_we    = 1'b1;
    lut_waddr = IDX_W'(idx);
    lut_wdata = PC_W'(val);
    tick(tag);
    quiet();
  endtask

  task automatic jump_to(input int idx, input string tag);
    quiet();
    jump_en    = 1'b1;
    target_idx = IDX_W'(idx);
    tick(tag);
    quiet();
  endtask

  initial begin
    int guard;
    quiet();
    for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
    m_running = 1'b0; m_finished = 1'b0; m_pc = 0; m_cnt = 0;

    // Reset state
    Reset = 1'b1;
    tick("reset0");
    tick("reset1");
    quiet();
    tick("idle");

    // Sequential execution from start
    start = 1'b1;
    tick("start");
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick("seq");

    // Taken / not-taken conditional branch at pc=7
    write_lut(3, 'h40, "lutw3");
    guard = 0;
    while (m_pc != 7 && guard < 20) begin tick("to7"); guard++; end
    branch_en = 1'b1; z = 1'b1; target_idx = 4'd3;
    tick("br_taken");
    write_lut(4, 7, "lutw4");
    jump_to(4, "jmp7");
    branch_en = 1'b1; z = 1'b0; target_idx = 4'd3;
    tick("br_not_taken");
    quiet();

    // start ignored while running
    start = 1'b1;
    tick("start_in_run");
    quiet();

    // Halt wins over everything at pc=0x12
    write_lut(5, 'h12, "lutw5");
    jump_to(5, "jmp12");
    halt = 1'b1; branch_en = 1'b1; z = 1'b1; jump_en = 1'b1; target_idx = 4'd3;
    tick("halt_all");
    tick("done_ignore_ctl");
    quiet();
    tick("done_hold");

    // Restart from DONE
    start = 1'b1;
    tick("restart");
    quiet();

    // Wrap from all-ones
    write_lut(6, 'h3FF, "lutw6");
    jump_to(6, "jmp3ff");
    tick("wrap");
    tick("after_wrap");

    // Read-before-write on the LUT
    write_lut(2, 'h20, "lutw2");
    lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 10'h010;
    jump_en = 1'b1; target_idx = 4'd2;
    tick("rbw_old");
    jump_to(2, "rbw_new");

    // Reset mid-run
    write_lut(7, 'h55, "lutw7");
    jump_to(7, "jmp55");
    Reset = 1'b1;
    tick("mid_reset");
    start = 1'b1;
    tick("start_under_reset");
    quiet();
    tick("idle_after_reset");
    start = 1'b1;
    tick("start_after_reset");
    quiet();
    jump_to(3, "lut_cleared");

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      Reset      = ($urandom_range(63) == 0);
      start      = ($urandom_range(7) == 0);
      halt       = ($urandom_range(15) == 0);
      branch_en  = ($urandom_range(3) == 0);
      z          = $urandom_range(1);
      jump_en    = ($urandom_range(5) == 0);
      target_idx = IDX_W'($urandom_range(LUT_N - 1));
      lut_we     = ($urandom_range(2) == 0);
      lut_waddr  = IDX_W'($urandom_range(LUT_N - 1));
      lut_wdata  = PC_W'($urandom);
      tick("rand");
    end
    quiet();

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
